// File: rtl/decoder2to4_seq.sv
// Registered 2-to-4 decoder fed by a valid/ready code FIFO; each code is
// replayed as a one-hot pattern on d0..d3 for HOLD cycles.
module decoder2to4_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b0,
  input  logic       b1,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       d0,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       out_active,
  output logic [7:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = 4;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t        state, state_nx;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    d_q;
  logic          full, empty, push, pop, hold_zero;

  assign full      = (occ == (AW+1)'(DEPTH));
  assign empty     = (occ == '0);
  assign hold_zero = (hold_cnt == '0);
  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign in_ready  = !rst && !full;
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = DRIVE;
      DRIVE:   if (hold_zero && empty) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      DRIVE:   pop = hold_zero && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {b1, b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      hold_cnt   <= '0;
      d_q        <= '0;
      out_active <= 1'b0;
      count      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (pop) begin
        d_q        <= 4'b0001 << mem[rd_ptr];
        hold_cnt   <= HW'(HOLD - 1);
        out_active <= 1'b1;
        count      <= count + 8'd1;
      end else if (state == DRIVE) begin
        if (!hold_zero) begin
          hold_cnt <= hold_cnt - 1'b1;
        end else begin
          d_q        <= '0;
          out_active <= 1'b0;
        end
      end
    end
  end

  assign d0 = d_q[0];
  assign d1 = d_q[1];
  assign d2 = d_q[2];
  assign d3 = d_q[3];
endmodule

// File: tb/tb_decoder2to4_seq.sv
// Bench for decoder2to4_seq: three instances with HOLD=1,2,3 checked every
// cycle against a queue-based model of the accept/replay behaviour.
module tb_decoder2to4_seq;
  localparam int NU    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0]      rst, b0, b1, iv, rdy, act;
  logic [NU-1:0][3:0] dq;
  logic [NU-1:0][7:0] cnt;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    decoder2to4_seq #(.DEPTH(DEPTH), .HOLD(g + 1)) u_dut (
      .clk(clk), .rst(rst[g]), .b0(b0[g]), .b1(b1[g]), .in_valid(iv[g]),
      .in_ready(rdy[g]), .d0(dq[g][0]), .d1(dq[g][1]), .d2(dq[g][2]),
      .d3(dq[g][3]), .out_active(act[g]), .count(cnt[g]));
  end

  // Model: pending producer codes, FIFO contents, and the pattern on display
  // with the number of cycles it still has to be shown.
  int q  [NU][$];
  int tx [NU][$];
  bit m_act [NU];
  int m_cur [NU];
  int m_rem [NU];
  int m_cnt [NU];
  int n_acc [NU];
  bit gappy [NU];
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      bit ready;
      ready = !rst[u] && (q[u].size() < DEPTH);
      if (rst[u]) begin
        q[u].delete();
        m_act[u] = 1'b0;
        m_rem[u] = 0;
        m_cnt[u] = 0;
      end else begin
        if (q[u].size() > 0 && (!m_act[u] || m_rem[u] == 1)) begin
          m_cur[u] = q[u].pop_front();
          m_rem[u] = u + 1;
          m_act[u] = 1'b1;
          m_cnt[u] = (m_cnt[u] + 1) % 256;
        end else if (m_act[u]) begin
          if (m_rem[u] > 1) m_rem[u]--;
          else m_act[u] = 1'b0;
        end
        if (iv[u] && ready) begin
          q[u].push_back(int'({b1[u], b0[u]}));
          void'(tx[u].pop_front());
          n_acc[u]++;
        end
      end
    end
  end

  function automatic logic [13:0] expv(int u);
    logic [3:0] d;
    d = m_act[u] ? 4'(1 << m_cur[u]) : 4'b0000;
    return {d, m_act[u], !rst[u] && (q[u].size() < DEPTH), 8'(m_cnt[u])};
  endfunction

  function automatic logic [13:0] obsv(int u);
    return {dq[u], act[u], rdy[u], cnt[u]};
  endfunction

  function automatic bool_busy(int u);
    return (tx[u].size() > 0) || (q[u].size() > 0) || m_act[u];
  endfunction

  // Producer: offer the head code each cycle (optionally with random gaps).
  task automatic tick();
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      if (tx[u].size() > 0 && (!gappy[u] || $urandom_range(0, 2) != 0)) begin
        iv[u] = 1'b1;
        {b1[u], b0[u]} = 2'(tx[u][0]);
      end else begin
        iv[u] = 1'b0;
        {b1[u], b0[u]} = 2'($urandom_range(0, 3));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int u);
    tx[u].delete();
    n_acc[u] = 0;
    rst[u] = 1'b1;
    tick();
    rst[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = '1;
    repeat (2) begin
      tick();
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u) || rdy[u] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    rst = '0;
    #1;
    n_chk++;
    if (rdy !== '1) begin
      n_fail++;
      $display("FAIL reset_release in_ready got %b want 111", rdy);
    end
  endtask

  task automatic test_single();
    int hi = 0, bud = 0;
    do_reset(1);
    tx[1].push_back(2);
    while (bool_busy(1) && bud < 100) begin
      tick(); bud++;
      if (dq[1] == 4'b0100) hi++;
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u)) begin
          n_fail++;
          $display("FAIL single u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    n_chk++;
    if (hi != 2 || cnt[1] !== 8'd1 || bud >= 100) begin
      n_fail++;
      $display("FAIL single_hold got hi=%0d count=%0d want hi=2 count=1", hi, cnt[1]);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] seen[$];
    logic [3:0] want[8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
    bit gap = 0;
    int bud = 0;
    do_reset(1);
    for (int c = 0; c < 4; c++) tx[1].push_back(c);
    while (bool_busy(1) && bud < 100) begin
      tick(); bud++;
      if (dq[1] != 4'b0) begin
        if (seen.size() > 0 && gap) gap = 1;
        seen.push_back(dq[1]);
      end else if (seen.size() > 0 && bool_busy(1)) gap = 1;
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u)) begin
          n_fail++;
          $display("FAIL sequence u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    n_chk++;
    if (seen.size() != 8 || gap || cnt[1] !== 8'd4) begin
      n_fail++;
      $display("FAIL sequence_order got n=%0d gap=%0d count=%0d want n=8 gap=0 count=4",
               seen.size(), gap, cnt[1]);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (seen[i] !== want[i]) begin
          n_fail++;
          $display("FAIL sequence_pat[%0d] got %b want %b", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int stall = 0, bud = 0;
    do_reset(2);
    for (int c = 0; c < 8; c++) tx[2].push_back($urandom_range(0, 3));
    while (bool_busy(2) && bud < 200) begin
      tick(); bud++;
      if (tx[2].size() > 0 && rdy[2] === 1'b0) stall++;
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u)) begin
          n_fail++;
          $display("FAIL overflow u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    n_chk++;
    if (stall == 0 || cnt[2] !== 8'd8 || n_acc[2] != 8 || bud >= 200) begin
      n_fail++;
      $display("FAIL overflow_end got stall=%0d count=%0d acc=%0d want stall>0 count=8 acc=8",
               stall, cnt[2], n_acc[2]);
    end
  endtask

  task automatic test_full_pushpop();
    int low_on_pop = 0, bud = 0;
    do_reset(2);
    for (int c = 0; c < 7; c++) tx[2].push_back(c % 4);
    while (bool_busy(2) && bud < 200) begin
      // Full FIFO with a pop due at the next edge: readiness must still be low.
      if (q[2].size() == DEPTH && m_rem[2] == 1 && rdy[2] === 1'b0) low_on_pop++;
      tick(); bud++;
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u)) begin
          n_fail++;
          $display("FAIL full_pushpop u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    n_chk++;
    if (low_on_pop == 0 || cnt[2] !== 8'd7 || n_acc[2] != 7) begin
      n_fail++;
      $display("FAIL full_pushpop_end got lowpop=%0d count=%0d acc=%0d want lowpop>0 count=7 acc=7",
               low_on_pop, cnt[2], n_acc[2]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    tx[2] = '{1, 0, 2, 3, 1};
    repeat (4) tick();
    n_chk++;
    if (dq[2] !== 4'b0010 || q[2].size() != 3) begin
      n_fail++;
      $display("FAIL reset_mid_setup got d=%b queued=%0d want d=0010 queued=3", dq[2], q[2].size());
    end
    tx[2].delete();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    n_chk++;
    if (dq[2] !== 4'b0 || act[2] !== 1'b0 || cnt[2] !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_flush got d=%b act=%b count=%0d want 0", dq[2], act[2], cnt[2]);
    end
    repeat (8) begin
      tick();
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u) || dq[2] !== 4'b0) begin
          n_fail++;
          $display("FAIL reset_mid_stale u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int low = 0, bud = 0;
    do_reset(0);
    for (int c = 0; c < 257; c++) tx[0].push_back($urandom_range(0, 3));
    while (bool_busy(0) && bud < 1000) begin
      tick(); bud++;
      if (tx[0].size() > 0 && rdy[0] !== 1'b1) low++;
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u)) begin
          n_fail++;
          $display("FAIL wrap u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    n_chk++;
    if (cnt[0] !== 8'd1 || low != 0 || n_acc[0] != 257 || bud >= 1000) begin
      n_fail++;
      $display("FAIL wrap_end got count=%0d rdy_low=%0d acc=%0d want count=1 rdy_low=0 acc=257",
               cnt[0], low, n_acc[0]);
    end
  endtask

  task automatic test_random();
    int bud = 0;
    for (int u = 0; u < NU; u++) begin
      do_reset(u);
      gappy[u] = 1'b1;
      for (int c = 0; c < 40; c++) tx[u].push_back($urandom_range(0, 3));
    end
    while ((bool_busy(0) || bool_busy(1) || bool_busy(2)) && bud < 2000) begin
      tick(); bud++;
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if (obsv(u) !== expv(u)) begin
          n_fail++;
          $display("FAIL random u%0d got %h want %h", u, obsv(u), expv(u));
        end
      end
    end
    for (int u = 0; u < NU; u++) begin
      n_chk++;
      if (cnt[u] !== 8'd40 || bud >= 2000) begin
        n_fail++;
        $display("FAIL random_end u%0d got count=%0d want 40", u, cnt[u]);
      end
      gappy[u] = 1'b0;
    end
  endtask

  initial begin
    rst = '1; iv = '0; b0 = '0; b1 = '0;
    for (int u = 0; u < NU; u++) begin
      m_act[u] = 0; m_cur[u] = 0; m_rem[u] = 0; m_cnt[u] = 0; n_acc[u] = 0; gappy[u] = 0;
    end
    test_reset();
    test_single();
    test_sequence();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
